uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver, the receive-side counterpart of the 8N1 transmitter. It synchronises the asynchronous serial line and detects start bits. It samples each bit at mid-period, LSB first, and checks the stop bit. Each good byte goes to the downstream consumer through a one-entry valid/ready output register, with frame-error and overrun flags.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz
BIT_RATE, 9600, serial bit rate in bit/s
(derived) CLKS_PER_BIT = CLK_HZ / BIT_RATE (integer divide); HALF_BIT = CLKS_PER_BIT / 2; CLKS_PER_BIT must be >= 4
(derived) counter width = 1 + clog2(CLKS_PER_BIT)

Ports:
clk_i  input  1  system clock, all logic on rising edge
nreset_i  input  1  reset, synchronous, active-low
rx_i  input  1  asynchronous serial line, idle high
rx_data_o  output  8  received byte, stable while valid_o is high
valid_o  output  1  rx_data_o holds an unconsumed byte
ready_i  input  1  consumer accepts the byte when valid_o && ready_i
frame_err_o  output  1  one-cycle pulse: stop bit sampled low
overrun_o  output  1  one-cycle pulse: good frame dropped because the output register was full

Behaviour:
- Reset (nreset_i low at a clock edge) has these effects:
  - state IDLE, bit counter 0, clock counter 0;
  - both synchroniser flops 1;
  - shift register 0, rx_data_o 0x00;
  - valid_o, frame_err_o and overrun_o all 0.
- Reset mid-frame abandons the frame. No output event is generated for the abandoned frame.
- Synchroniser: rx_i passes through 2 flops. rx_s is the second flop. All decisions use rx_s only.
- Clock counter: cleared on every state entry. It increments by 1 per cycle while in START, DATA or STOP. A "tick" is counter == period-1; the counter clears to 0 on a tick.
- State machine: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: enter START in the cycle after rx_s is seen 0.
  - START: tick period is HALF_BIT. On the tick, sample rx_s:
    - 1: glitch, return to IDLE, no flags;
    - 0: go to DATA, bit index 0.
  - DATA: tick period is CLKS_PER_BIT. On each tick, shift register bit[index] <= rx_s and index increments. After the tick for index 7, go to STOP.
  - STOP: tick period is CLKS_PER_BIT. On the tick, sample rx_s:
    - 1: good frame, go to IDLE;
    - 0: frame_err_o = 1 for the following cycle, byte discarded, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s == 1, then go to IDLE. A held break produces exactly one frame_err_o pulse.
- Sampling point: each data and stop bit is sampled about mid-bit, HALF_BIT + k*CLKS_PER_BIT cycles after start detection.
- Output register, on a good frame:
  - valid_o = 0, or valid_o = 1 with ready_i = 1 in the same cycle: rx_data_o <= byte and valid_o stays/becomes 1 next cycle. No overrun.
  - valid_o = 1 and ready_i = 0: old byte retained, new byte dropped, overrun_o = 1 for one cycle.
- Handshake:
  - valid_o rises in the cycle after the stop-bit tick.
  - valid_o stays high, with rx_data_o unchanged, until a cycle with ready_i = 1. It is low the next cycle unless a simultaneous good frame reloads it.
  - ready_i is ignored while valid_o = 0.
- Latency: from the rx_i falling edge to valid_o high is 2 + 1 + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles, ±1.
- Back-to-back frames:
  - the next start bit is detectable from the first IDLE cycle after STOP;
  - the receiver tolerates the stop bit being shortened by up to HALF_BIT.

Test Plan:
1. Use CLK_HZ=16, BIT_RATE=1 (CLKS_PER_BIT=16) with ready_i=0. Send 0xA5 -> valid_o=1 and rx_data_o=0xA5 within 2+1+8+144+1 cycles ±1. Both stay held for 50 cycles. Assert ready_i for 1 cycle -> valid_o=0 the next cycle.
2. Pulse rx_i low for 3 cycles, then hold it high -> no valid_o, no frame_err_o, FSM back in IDLE. Then send 0x5A -> received correctly.
3. Send 0x3C with the stop bit low, then hold rx_i low for 3 bit times -> exactly one frame_err_o pulse and no valid_o. After rx_i goes high, 0x81 is received correctly.
4. Hold ready_i=0 and send 0x11 then 0x22 -> rx_data_o=0x11 and one overrun_o pulse after the second stop bit. With ready_i=1 on the final stop tick, 0x22 loads instead and there is no overrun.
5. Hold ready_i=1 and send 0x00, 0xFF, 0x80 back-to-back, each with a stop bit shortened by 4 cycles -> three handshakes with the values in order, no flags.
6. Assert nreset_i low during data bit 4 of a frame, release it, then send 0xC3 -> all outputs 0 during reset, no event for the partial frame, and 0xC3 is received.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver. The asynchronous line is double-flopped and
//            start bits are detected on it. Data bits are sampled mid-bit,
//            LSB first, and the stop bit is checked. Good bytes are presented
//            through a one-entry valid/ready output register.
// Ports    : clk_i        system clock, rising edge
//            nreset_i     synchronous active-low reset
//            rx_i         asynchronous serial line, idle high
//            rx_data_o    received byte, stable while valid_o is high
//            valid_o      rx_data_o holds an unconsumed byte
//            ready_i      consumer accepts the byte when valid_o && ready_i
//            frame_err_o  one-cycle pulse, stop bit sampled low
//            overrun_o    one-cycle pulse, good byte dropped (register full)
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int BIT_RATE = 9600
) (
  input  logic       clk_i,
  input  logic       nreset_i,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o
);

  // CLKS_PER_BIT is expected to be at least 4 so HALF_BIT is non-trivial.
  localparam int CLKS_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = 1 + $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] C_FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_frame_err;
  logic             r_overrun;

  logic             w_rx_s;
  logic             w_tick;
  logic             w_counting;
  logic             w_sample;
  logic             w_good;
  logic             w_bad;
  logic             w_load;
  logic             w_drop;

  assign w_rx_s = r_sync2;

  // --------------------------------------------------------------------------
  // Next-state and per-cycle decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_tick       = 1'b0;
    w_counting   = 1'b0;
    w_sample     = 1'b0;
    w_good       = 1'b0;
    w_bad        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) begin
          w_state_next = ST_START;
        end
      end

      ST_START: begin
        w_counting = 1'b1;
        w_tick     = (r_cnt == C_HALF_LAST);
        if (w_tick) begin
          // Line back high at mid start bit: treat as a glitch.
          w_state_next = w_rx_s ? ST_IDLE : ST_DATA;
        end
      end

      ST_DATA: begin
        w_counting = 1'b1;
        w_tick     = (r_cnt == C_FULL_LAST);
        if (w_tick) begin
          w_sample = 1'b1;
          if (r_bit_idx == 3'd7) begin
            w_state_next = ST_STOP;
          end
        end
      end

      ST_STOP: begin
        w_counting = 1'b1;
        w_tick     = (r_cnt == C_FULL_LAST);
        if (w_tick) begin
          if (w_rx_s) begin
            w_good       = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_bad        = 1'b1;
            w_state_next = ST_WAIT_IDLE;
          end
        end
      end

      ST_WAIT_IDLE: begin
        // A held break must not retrigger start detection.
        if (w_rx_s) begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // A simultaneous consume frees the register for the incoming byte.
  assign w_load = w_good && (!r_valid || ready_i);
  assign w_drop = w_good && r_valid && !ready_i;

  // --------------------------------------------------------------------------
  // State register and datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      r_state     <= ST_IDLE;
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_cnt       <= '0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
      r_state <= w_state_next;

      // Counter restarts on every state entry and on every tick.
      if (!w_counting || w_tick || (w_state_next != r_state)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // Index wraps 7 -> 0 on the last data tick; held at 0 outside DATA.
      if (w_sample) begin
        r_shift[r_bit_idx] <= w_rx_s;
        r_bit_idx          <= r_bit_idx + 3'd1;
      end else if (r_state != ST_DATA) begin
        r_bit_idx <= 3'd0;
      end

      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (ready_i) begin
        r_valid <= 1'b0;
      end

      r_frame_err <= w_bad;
      r_overrun   <= w_drop;
    end
  end

  assign rx_data_o   = r_data;
  assign valid_o     = r_valid;
  assign frame_err_o = r_frame_err;
  assign overrun_o   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Directed self-checking bench for uart_rx with CLKS_PER_BIT = 16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  logic       clk      = 1'b0;
  logic       nreset_i = 1'b0;
  logic       rx_i     = 1'b1;
  logic       ready_i  = 1'b0;
  logic [7:0] rx_data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;

  uart_rx #(
    .CLK_HZ   (16),
    .BIT_RATE (1)
  ) dut (
    .clk_i       (clk),
    .nreset_i    (nreset_i),
    .rx_i        (rx_i),
    .rx_data_o   (rx_data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc_n    = 0;
  int         n_ferr   = 0;
  int         n_ovr    = 0;
  int         n_vrise  = 0;
  int         t_rise   = -1;
  int         t_fall   = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] hs_q[$];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Event monitor sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (nreset_i) begin
      if (frame_err_o) n_ferr <= n_ferr + 1;
      if (overrun_o)   n_ovr  <= n_ovr + 1;
      if (valid_o && !prev_valid) begin
        n_vrise <= n_vrise + 1;
        t_rise  <= cyc_n;
      end
      if (valid_o && ready_i) hs_q.push_back(rx_data_o);
    end
    prev_valid <= valid_o;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {present, byte} of the oldest handshake; 0 if none happened.
  function automatic logic [8:0] hs_pop();
    if (hs_q.size() == 0) return 9'h000;
    return {1'b1, hs_q.pop_front()};
  endfunction

  // One 8N1 frame, 16 cycles per bit. Optionally raise ready_i for exactly
  // the cycle whose edge is the stop-bit tick (11th edge of the stop bit).
  task automatic send(input logic [7:0] b, input logic stop_v, input int stop_len,
                      input bit rdy_at_tick);
    rx_i   = 1'b0;
    t_fall = cyc_n;
    cyc(16);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      cyc(16);
    end
    rx_i = stop_v;
    if (rdy_at_tick) begin
      cyc(10);
      ready_i = 1'b1;
      cyc(1);
      ready_i = 1'b0;
      cyc(stop_len - 11);
    end else begin
      cyc(stop_len);
    end
    rx_i = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int         lat;
    int         vr_base;
    logic [2:0] st;

    // ---------------- reset state ----------------
    cyc(3);
    check("reset_valid", {31'd0, valid_o}, 32'd0);
    check("reset_data", {24'd0, rx_data_o}, 32'h00);
    check("reset_ferr", {31'd0, frame_err_o}, 32'd0);
    check("reset_ovr", {31'd0, overrun_o}, 32'd0);
    nreset_i = 1'b1;
    cyc(5);

    // ---------------- 1: basic receive and hold ----------------
    ready_i = 1'b0;
    send(8'hA5, 1'b1, 16, 1'b0);
    lat = t_rise - t_fall;
    check("t1_valid", {31'd0, valid_o}, 32'd1);
    check("t1_data", {24'd0, rx_data_o}, 32'hA5);
    check("t1_latency_window", {31'd0, (lat >= 155 && lat <= 157)}, 32'd1);
    cyc(50);
    check("t1_valid_held", {31'd0, valid_o}, 32'd1);
    check("t1_data_held", {24'd0, rx_data_o}, 32'hA5);
    ready_i = 1'b1;
    cyc(1);
    ready_i = 1'b0;
    check("t1_valid_drop", {31'd0, valid_o}, 32'd0);
    check("t1_handshake", {23'd0, hs_pop()}, 32'h1A5);

    // ---------------- 2: glitch rejection ----------------
    rx_i = 1'b0;
    cyc(3);
    rx_i = 1'b1;
    cyc(30);
    st = dut.r_state;
    check("t2_no_valid", {31'd0, valid_o}, 32'd0);
    check("t2_no_ferr", n_ferr, 32'd0);
    check("t2_idle", {29'd0, st}, 32'd0);
    send(8'h5A, 1'b1, 16, 1'b0);
    check("t2_valid", {31'd0, valid_o}, 32'd1);
    check("t2_data", {24'd0, rx_data_o}, 32'h5A);
    ready_i = 1'b1;
    cyc(1);
    ready_i = 1'b0;
    check("t2_handshake", {23'd0, hs_pop()}, 32'h15A);

    // ---------------- 3: framing error with held break ----------------
    vr_base = n_vrise;
    send(8'h3C, 1'b0, 16, 1'b0);
    rx_i = 1'b0;
    cyc(48);
    rx_i = 1'b1;
    cyc(20);
    check("t3_one_ferr", n_ferr, 32'd1);
    check("t3_no_valid_rise", n_vrise, vr_base);
    check("t3_valid_low", {31'd0, valid_o}, 32'd0);
    ready_i = 1'b1;
    send(8'h81, 1'b1, 16, 1'b0);
    cyc(5);
    ready_i = 1'b0;
    check("t3_recover", {23'd0, hs_pop()}, 32'h181);
    check("t3_ferr_still_one", n_ferr, 32'd1);

    // ---------------- 4: overrun ----------------
    send(8'h11, 1'b1, 16, 1'b0);
    send(8'h22, 1'b1, 16, 1'b0);
    cyc(5);
    check("t4_valid", {31'd0, valid_o}, 32'd1);
    check("t4_old_kept", {24'd0, rx_data_o}, 32'h11);
    check("t4_one_ovr", n_ovr, 32'd1);
    ready_i = 1'b1;
    cyc(1);
    ready_i = 1'b0;
    check("t4_hs_old", {23'd0, hs_pop()}, 32'h111);
    send(8'h11, 1'b1, 16, 1'b0);
    send(8'h22, 1'b1, 16, 1'b1);
    cyc(5);
    check("t4_simul_valid", {31'd0, valid_o}, 32'd1);
    check("t4_simul_data", {24'd0, rx_data_o}, 32'h22);
    check("t4_simul_no_ovr", n_ovr, 32'd1);
    check("t4_simul_hs", {23'd0, hs_pop()}, 32'h111);
    ready_i = 1'b1;
    cyc(1);
    ready_i = 1'b0;
    check("t4_hs_new", {23'd0, hs_pop()}, 32'h122);
    check("t4_valid_drop", {31'd0, valid_o}, 32'd0);

    // ---------------- 5: back-to-back, short stop bits ----------------
    ready_i = 1'b1;
    send(8'h00, 1'b1, 12, 1'b0);
    send(8'hFF, 1'b1, 12, 1'b0);
    send(8'h80, 1'b1, 12, 1'b0);
    cyc(20);
    ready_i = 1'b0;
    check("t5_hs0", {23'd0, hs_pop()}, 32'h100);
    check("t5_hs1", {23'd0, hs_pop()}, 32'h1FF);
    check("t5_hs2", {23'd0, hs_pop()}, 32'h180);
    check("t5_no_extra", hs_q.size(), 32'd0);
    check("t5_ferr", n_ferr, 32'd1);
    check("t5_ovr", n_ovr, 32'd1);

    // ---------------- 6: reset mid-frame ----------------
    vr_base = n_vrise;
    rx_i = 1'b0;
    cyc(16);
    for (int i = 0; i < 4; i++) begin
      rx_i = (i == 0) ? 1'b1 : 1'b0;
      cyc(16);
    end
    rx_i = 1'b1;
    cyc(8);
    nreset_i = 1'b0;
    cyc(1);
    check("t6_rst_data", {24'd0, rx_data_o}, 32'h00);
    check("t6_rst_valid", {31'd0, valid_o}, 32'd0);
    check("t6_rst_flags", {30'd0, frame_err_o, overrun_o}, 32'd0);
    cyc(2);
    nreset_i = 1'b1;
    cyc(200);
    check("t6_no_event_valid", n_vrise, vr_base);
    check("t6_no_event_ferr", n_ferr, 32'd1);
    ready_i = 1'b1;
    send(8'hC3, 1'b1, 16, 1'b0);
    cyc(5);
    ready_i = 1'b0;
    check("t6_hs", {23'd0, hs_pop()}, 32'h1C3);
    check("t6_no_extra", hs_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
